// File: rtl/lvds_rx_framer.sv
// Serial-to-parallel framer behind an LVDS input buffer: resynchronises the bit stream,
// hunts for a periodic sync word and emits aligned words once lock is established.
module lvds_rx_framer #(
  parameter int             W          = 8,
  parameter logic [W-1:0]   SYNC_WORD  = W'('h47),
  parameter int             FRAME_LEN  = 16,
  parameter int             VERIFY_CNT = 2,
  parameter int             LOSS_CNT   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_bit,
  input  logic         bit_en,
  output logic [W-1:0] data_o,
  output logic         data_vld,
  output logic         sof,
  output logic         locked,
  output logic         sync_err
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int WW = $clog2(FRAME_LEN);
  localparam int GW = $clog2(VERIFY_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;

  state_t          state_q, state_d;
  logic            rx_s1_q, rx_s2_q, en_s1_q, en_s2_q;
  logic [W-1:0]    sr_q, sr_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [GW-1:0]   good_q, good_d;
  logic [MW-1:0]   miss_q, miss_d;
  logic [W-1:0]    data_q, data_d;
  logic            data_vld_q, data_vld_d;
  logic            sof_q, sof_d;
  logic            sync_err_q, sync_err_d;

  logic [W-1:0]    sr_shift;
  logic            word_done, sync_hit, sync_slot;

  // Everything downstream sees the shift register as it will be after this bit.
  assign sr_shift  = {sr_q[W-2:0], rx_s2_q};
  assign word_done = (bcnt_q == BW'(W - 1));
  assign sync_hit  = (sr_shift == SYNC_WORD);
  assign sync_slot = word_done && (wcnt_q == '0);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= ST_HUNT;
      rx_s1_q    <= 1'b0;
      rx_s2_q    <= 1'b0;
      en_s1_q    <= 1'b0;
      en_s2_q    <= 1'b0;
      sr_q       <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      good_q     <= '0;
      miss_q     <= '0;
      data_q     <= '0;
      data_vld_q <= 1'b0;
      sof_q      <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_s1_q    <= rx_bit;
      rx_s2_q    <= rx_s1_q;
      en_s1_q    <= bit_en;
      en_s2_q    <= en_s1_q;
      sr_q       <= sr_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      good_q     <= good_d;
      miss_q     <= miss_d;
      data_q     <= data_d;
      data_vld_q <= data_vld_d;
      sof_q      <= sof_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (en_s2_q) begin
      unique case (state_q)
        ST_HUNT:   if (sync_hit) state_d = ST_VERIFY;
        ST_VERIFY: if (sync_slot) begin
                     if (!sync_hit)                             state_d = ST_HUNT;
                     else if (good_q + GW'(1) == GW'(VERIFY_CNT)) state_d = ST_LOCKED;
                   end
        ST_LOCKED: if (sync_slot && !sync_hit && (miss_q + MW'(1) == MW'(LOSS_CNT)))
                     state_d = ST_HUNT;
        default:   state_d = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    // NOTE: every combinational output is defaulted first so no latch can be inferred.
    sr_d       = sr_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    good_d     = good_q;
    miss_d     = miss_q;
    data_d     = data_q;
    data_vld_d = 1'b0;
    sof_d      = 1'b0;
    sync_err_d = 1'b0;
    if (en_s2_q) begin
      sr_d   = sr_shift;
      bcnt_d = word_done ? '0 : bcnt_q + BW'(1);
      if (word_done)
        wcnt_d = (wcnt_q == WW'(FRAME_LEN - 1)) ? '0 : wcnt_q + WW'(1);
      unique case (state_q)
        ST_HUNT: if (sync_hit) begin
          // Re-align: the next bit starts word slot 1.
          bcnt_d = '0;
          wcnt_d = WW'(1);
          good_d = '0;
        end
        ST_VERIFY: if (sync_slot && sync_hit) begin
          good_d = good_q + GW'(1);
          miss_d = '0;
        end
        ST_LOCKED: if (word_done) begin
          if (wcnt_q != '0) begin
            data_d     = sr_shift;
            data_vld_d = 1'b1;
            sof_d      = (wcnt_q == WW'(1));
          end else if (sync_hit) begin
            miss_d = '0;
          end else begin
            sync_err_d = 1'b1;
            miss_d     = miss_q + MW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    locked = (state_q == ST_LOCKED);
  end

  assign data_o   = data_q;
  assign data_vld = data_vld_q;
  assign sof      = sof_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_lvds_rx_framer.sv
// Scoreboard bench for lvds_rx_framer: a frame-level model predicts events per serial bit,
// the driver queues them with their due cycle and a monitor matches DUT outputs.
module tb_lvds_rx_framer;

  localparam int         W          = 8;
  localparam int         FL         = 16;
  localparam int         VERIFY_CNT = 2;
  localparam int         LOSS_CNT   = 3;
  localparam logic [7:0] SYNC       = 8'h47;

  typedef struct { int cyc; bit [7:0] d; bit sof; } dev_t;
  typedef struct { int cyc; bit v; } lev_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_bit = 1'b0;
  logic         bit_en = 1'b0;
  logic [W-1:0] data_o;
  logic         data_vld, sof, locked, sync_err;

  lvds_rx_framer dut (
    .clk(clk), .rst(rst), .rx_bit(rx_bit), .bit_en(bit_en),
    .data_o(data_o), .data_vld(data_vld), .sof(sof), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0, n_fail = 0;
  int   n_dv = 0, n_err = 0;
  bit   mon_en = 1'b0, gap_chk = 1'b0;
  int   last_dv_cyc = -1;
  logic [7:0] last_data = '0;
  logic prev_locked = 1'b0;

  dev_t dq[$];
  int   eq[$];
  lev_t lq[$];

  bit       seg[$];
  bit       e_dv[], e_sof[], e_err[];
  bit [7:0] e_d[];
  int       e_lk[];
  bit       model_locked = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic missed(input string name, input int due);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: no DUT event, expected one at cycle %0d (now %0d)", name, due, cyc);
  endtask

  // ---------------- reference model (frame arithmetic on the bit stream) ----------------
  function automatic bit [7:0] word_at(int i);
    bit [7:0] w = '0;
    for (int k = i - 7; k <= i; k++) w = {w[6:0], (k >= 0) ? seg[k] : 1'b0};
    return w;
  endfunction

  task automatic build_model();
    int n = seg.size();
    int pos = 0, i, s, base, miss;
    bit fin = 1'b0, ok;
    e_dv = new[n]; e_sof = new[n]; e_err = new[n]; e_d = new[n]; e_lk = new[n];
    foreach (e_lk[k]) e_lk[k] = -1;
    model_locked = 1'b0;
    while (!fin) begin
      i = pos;
      while (i < n && word_at(i) != SYNC) i++;
      if (i >= n) break;
      ok = 1'b1;
      for (int k = 1; k <= VERIFY_CNT; k++) begin
        s = i + k * FL * W;
        if (s >= n) begin fin = 1'b1; ok = 1'b0; break; end
        if (word_at(s) != SYNC) begin ok = 1'b0; pos = s + 1; break; end
      end
      if (!ok) continue;
      base = i + VERIFY_CNT * FL * W;
      e_lk[base] = 1;
      model_locked = 1'b1;
      miss = 0;
      while (model_locked && !fin) begin
        for (int j = 1; j < FL; j++) begin
          s = base + j * W;
          if (s >= n) begin fin = 1'b1; break; end
          e_dv[s] = 1'b1; e_d[s] = word_at(s); e_sof[s] = (j == 1);
        end
        if (fin) break;
        s = base + FL * W;
        if (s >= n) begin fin = 1'b1; break; end
        if (word_at(s) == SYNC) miss = 0;
        else begin
          e_err[s] = 1'b1;
          miss++;
          if (miss == LOSS_CNT) begin e_lk[s] = 0; model_locked = 1'b0; pos = s + 1; end
        end
        base = s;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic add_word(input bit [7:0] w);
    for (int k = 7; k >= 0; k--) seg.push_back(w[k]);
  endtask

  task automatic add_frame(input bit [7:0] sync_w);
    add_word(sync_w);
    for (int j = 1; j < FL; j++) add_word(8'(j));
  endtask

  // Random prefix that cannot itself form a sync word before the real one.
  task automatic add_prefix(input int k);
    bit ok;
    do begin
      seg.delete();
      for (int j = 0; j < k; j++) seg.push_back(1'($urandom));
      add_word(SYNC);
      ok = 1'b1;
      for (int i = 0; i < k + 7; i++) if (word_at(i) == SYNC) ok = 1'b0;
      repeat (8) void'(seg.pop_back());
    end while (!ok);
  endtask

  task automatic play(input int gap);
    int g, c;
    build_model();
    for (int n = 0; n < seg.size(); n++) begin
      g = (gap >= 0) ? gap : int'($urandom_range(2, 0));
      repeat (g) begin @(posedge clk); #1 bit_en = 1'b0; rx_bit = 1'($urandom); end
      @(posedge clk); #1 bit_en = 1'b1; rx_bit = seg[n]; c = cyc;
      if (e_dv[n])     dq.push_back('{cyc: c + 3, d: e_d[n], sof: e_sof[n]});
      if (e_err[n])    eq.push_back(c + 3);
      if (e_lk[n] >= 0) lq.push_back('{cyc: c + 3, v: e_lk[n][0]});
    end
    @(posedge clk); #1 bit_en = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 bit_en = 1'b0; rx_bit = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    if (model_locked) lq.push_back('{cyc: cyc + 1, v: 1'b0});
    model_locked = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    check("rst_locked",   locked,   0);
    check("rst_data_vld", data_vld, 0);
    check("rst_sof",      sof,      0);
    check("rst_sync_err", sync_err, 0);
    check("rst_data_o",   data_o,   0);
    n_dv = 0; n_err = 0; last_dv_cyc = -1;
  endtask

  // ---------------- monitor ----------------
  int mon_exp;
  dev_t mon_dev;
  always @(negedge clk) begin
    if (mon_en) begin
      while (dq.size() != 0 && dq[0].cyc < cyc) begin missed("data_vld", dq[0].cyc); void'(dq.pop_front()); end
      while (eq.size() != 0 && eq[0] < cyc)     begin missed("sync_err", eq[0]);     void'(eq.pop_front()); end
      while (lq.size() != 0 && lq[0].cyc < cyc) begin missed("locked_edge", lq[0].cyc); void'(lq.pop_front()); end
      if (rst) last_data = '0;
      if (data_vld === 1'b1) begin
        mon_exp = (dq.size() != 0) ? dq[0].cyc : -1;
        check("data_vld_cycle", cyc, mon_exp);
        if (mon_exp == cyc) begin
          mon_dev = dq.pop_front();
          check("data_o", data_o, mon_dev.d);
          check("sof", sof, mon_dev.sof);
          if (gap_chk && !mon_dev.sof && last_dv_cyc >= 0) check("dv_spacing", cyc - last_dv_cyc, 24);
          last_dv_cyc = cyc;
          last_data = mon_dev.d;
          n_dv++;
        end
      end else if (!rst) begin
        check("data_hold", data_o, last_data);
        check("sof_idle", sof, 0);
      end
      if (sync_err === 1'b1) begin
        mon_exp = (eq.size() != 0) ? eq[0] : -1;
        check("sync_err_cycle", cyc, mon_exp);
        if (mon_exp == cyc) begin void'(eq.pop_front()); n_err++; end
      end
      if (locked !== prev_locked) begin
        mon_exp = (lq.size() != 0) ? lq[0].cyc : -1;
        check("locked_cycle", cyc, mon_exp);
        if (mon_exp == cyc) begin
          check("locked_value", locked, lq[0].v);
          void'(lq.pop_front());
        end
      end
      prev_locked = locked;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    bit [7:0] sw;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("init_locked",   locked,   0);
    check("init_data_vld", data_vld, 0);
    check("init_data_o",   data_o,   0);
    mon_en = 1'b1;

    // Acquisition
    do_reset();
    add_prefix(3);
    repeat (4) add_frame(SYNC);
    play(0);
    check("acq_dv_count", n_dv, 30);
    check("acq_locked", locked, 1);

    // Arbitrary bit offsets
    for (int k = 0; k < 8; k++) begin
      do_reset();
      add_prefix(k);
      repeat (4) add_frame(SYNC);
      play(0);
      check("offset_dv_count", n_dv, 30);
      check("offset_locked", locked, 1);
    end

    // Loss of lock: 2 misses recover, 3 misses drop, then re-acquire
    do_reset();
    add_prefix(3);
    repeat (4) add_frame(SYNC);
    repeat (2) add_frame(8'h46);
    repeat (2) add_frame(SYNC);
    repeat (3) add_frame(8'h46);
    repeat (4) add_frame(SYNC);
    play(0);
    check("loss_err_count", n_err, 5);
    check("loss_dv_count", n_dv, 150);
    check("loss_relocked", locked, 1);

    // Verify failure on a false sync
    do_reset();
    add_prefix(3);
    add_word(SYNC);
    for (int j = 16; j < 31; j++) add_word(8'(j));
    add_word(8'h55);
    repeat (4) add_frame(SYNC);
    play(0);
    check("vfail_dv_count", n_dv, 30);

    // Strobe gaps: one bit every third cycle
    do_reset();
    gap_chk = 1'b1;
    add_prefix(3);
    repeat (4) add_frame(SYNC);
    play(2);
    gap_chk = 1'b0;
    check("gap_dv_count", n_dv, 30);

    // Reset mid-frame while locked
    do_reset();
    add_prefix(3);
    repeat (3) add_frame(SYNC);
    add_word(SYNC);
    for (int j = 1; j < 7; j++) add_word(8'(j));
    play(0);
    check("mid_locked", locked, 1);
    do_reset();
    add_prefix(3);
    repeat (4) add_frame(SYNC);
    play(0);
    check("relock_dv_count", n_dv, 30);

    // Randomised frames, data, sync corruption and strobe gaps
    for (int r = 0; r < 3; r++) begin
      do_reset();
      add_prefix(int'($urandom_range(7, 0)));
      for (int f = 0; f < 10; f++) begin
        sw = ($urandom_range(4, 0) == 0) ? (SYNC ^ (8'h01 << $urandom_range(7, 0))) : SYNC;
        add_word(sw);
        for (int j = 1; j < FL; j++) add_word(8'($urandom));
      end
      play(-1);
    end

    repeat (10) @(posedge clk);
    check("pending_data_events", dq.size(), 0);
    check("pending_err_events", eq.size(), 0);
    check("pending_lock_events", lq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
